// File: rtl/branch_ctrl.sv
// branch_ctrl: decodes the current instruction and drives the fetch unit's
// branch controls. Also runs the start/halt handshake with the bench, keeps
// a programmable absolute-target LUT, a latched condition flag and a
// saturating taken-branch counter.
module branch_ctrl #(
    parameter int unsigned PC_WIDTH    = 11,
    parameter int unsigned INSTR_WIDTH = 9,
    parameter int unsigned LUT_DEPTH   = 16
) (
    input  logic                   ckl,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   ALU_flag,
    input  logic                   lut_we,
    input  logic [3:0]             lut_addr,
    input  logic [PC_WIDTH-1:0]    lut_wdata,
    output logic                   branch_abs,
    output logic                   branch_rel,
    output logic [PC_WIDTH-1:0]    Target,
    output logic                   done,
    output logic [15:0]            taken_cnt
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned OFF_W = 5;
    localparam int unsigned CNT_W = 16;

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Opcodes (instr[8:5])
    localparam logic [OP_W-1:0] OP_BRA  = 4'b1110;
    localparam logic [OP_W-1:0] OP_BAZ  = 4'b1101;
    localparam logic [OP_W-1:0] OP_BRZ  = 4'b1100;
    localparam logic [OP_W-1:0] OP_CMP  = 4'b1010;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]          state_q, state_d;
    logic                flag_q,  flag_d;
    logic                done_q,  done_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [PC_WIDTH-1:0] lut_q [LUT_DEPTH];
    logic [PC_WIDTH-1:0] lut_d [LUT_DEPTH];

    logic [OP_W-1:0]     opcode;
    logic [3:0]          lut_idx;
    logic [OFF_W-1:0]    rel_off;
    logic [PC_WIDTH-1:0] lut_rd;
    logic [PC_WIDTH-1:0] rel_tgt;
    logic                taken;

    assign opcode  = instr[INSTR_WIDTH-1 -: OP_W];
    assign lut_idx = instr[3:0];
    assign rel_off = instr[OFF_W-1:0];
    // Combinational read sees the pre-write contents in a same-cycle write
    assign lut_rd  = lut_q[lut_idx];
    assign rel_tgt = {{(PC_WIDTH-OFF_W){rel_off[OFF_W-1]}}, rel_off};

    assign done      = done_q;
    assign taken_cnt = cnt_q;

    // State, flag, counter and done registers
    always_ff @(posedge ckl or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Target LUT storage, cleared by reset
    always_ff @(posedge ckl or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    // LUT write port, active in any state
    always_comb begin
        for (int i = 0; i < int'(LUT_DEPTH); i++) begin
            lut_d[i] = lut_q[i];
        end
        if (lut_we) begin
            lut_d[lut_addr] = lut_wdata;
        end
    end

    // Decode, branch outputs and next-state logic
    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        cnt_d      = cnt_q;
        taken      = 1'b0;
        branch_abs = 1'b0;
        branch_rel = 1'b0;
        Target     = '0;

        case (state_q)
            S_RUN: begin
                case (opcode)
                    OP_BRA: begin
                        branch_abs = 1'b1;
                        Target     = lut_rd;
                        taken      = 1'b1;
                    end
                    OP_BAZ: begin
                        if (flag_q) begin
                            branch_abs = 1'b1;
                            Target     = lut_rd;
                            taken      = 1'b1;
                        end
                    end
                    OP_BRZ: begin
                        if (flag_q) begin
                            branch_rel = 1'b1;
                            Target     = rel_tgt;
                            taken      = 1'b1;
                        end
                    end
                    OP_CMP: begin
                        flag_d = ALU_flag;
                    end
                    OP_HALT: begin
                        state_d = S_DONE;
                    end
                    default: ;
                endcase
            end
            default: begin
                // IDLE and DONE hold the PC: add zero
                branch_rel = 1'b1;
            end
        endcase

        if (taken && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Start overrides everything, including a HALT in the same cycle
        if (start) begin
            state_d = S_RUN;
            flag_d  = 1'b0;
            cnt_d   = '0;
        end

        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Table-driven bench for branch_ctrl plus hand sequences for counter
// saturation and asynchronous reset.
module tb_branch_ctrl;

    localparam int unsigned PW = 11;
    localparam int unsigned IW = 9;

    logic          ckl;
    logic          reset;
    logic          start;
    logic [IW-1:0] instr;
    logic          ALU_flag;
    logic          lut_we;
    logic [3:0]    lut_addr;
    logic [PW-1:0] lut_wdata;
    logic          branch_abs;
    logic          branch_rel;
    logic [PW-1:0] Target;
    logic          done;
    logic [15:0]   taken_cnt;

    int checks;
    int errors;

    branch_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .LUT_DEPTH(16)) dut (
        .ckl        (ckl),
        .reset      (reset),
        .start      (start),
        .instr      (instr),
        .ALU_flag   (ALU_flag),
        .lut_we     (lut_we),
        .lut_addr   (lut_addr),
        .lut_wdata  (lut_wdata),
        .branch_abs (branch_abs),
        .branch_rel (branch_rel),
        .Target     (Target),
        .done       (done),
        .taken_cnt  (taken_cnt)
    );

    initial ckl = 1'b0;
    always #5 ckl = ~ckl;

    typedef struct {
        logic          start;
        logic [IW-1:0] instr;
        logic          alu;
        logic          we;
        logic [3:0]    wa;
        logic [PW-1:0] wd;
        logic          e_abs;   // before the edge
        logic          e_rel;
        logic [PW-1:0] e_tgt;
        logic          e_done;  // after the edge
        logic [15:0]   e_cnt;
    } vec_t;

    localparam logic [IW-1:0] NOP   = 9'b0000_00000;
    localparam logic [IW-1:0] BRA3  = 9'b1110_0_0011;
    localparam logic [IW-1:0] BRA5  = 9'b1110_0_0101;
    localparam logic [IW-1:0] BAZ3  = 9'b1101_0_0011;
    localparam logic [IW-1:0] BRZM4 = 9'b1100_11100;
    localparam logic [IW-1:0] BRZP  = 9'b1100_01111;
    localparam logic [IW-1:0] CMP   = 9'b1010_00000;
    localparam logic [IW-1:0] HALT  = 9'b1111_00000;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic s, input logic [IW-1:0] ins, input logic alu,
                           input logic we, input logic [3:0] wa, input logic [PW-1:0] wd,
                           input logic ea, input logic er, input logic [PW-1:0] et,
                           input logic ed, input logic [15:0] ec);
        vecs[i] = '{s, ins, alu, we, wa, wd, ea, er, et, ed, ec};
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //        idx st instr  alu we wa  wd       abs rel tgt      done cnt
        set_vec(0,  0, NOP,   0, 0, 0, 11'h000, 0, 1, 11'h000, 0, 0);
        set_vec(1,  0, BRA3,  0, 0, 0, 11'h000, 0, 1, 11'h000, 0, 0);
        set_vec(2,  0, HALT,  0, 0, 0, 11'h000, 0, 1, 11'h000, 0, 0);
        set_vec(3,  0, NOP,   0, 1, 3, 11'h155, 0, 1, 11'h000, 0, 0);
        set_vec(4,  1, NOP,   0, 0, 0, 11'h000, 0, 1, 11'h000, 0, 0);
        set_vec(5,  0, BRA3,  0, 0, 0, 11'h000, 1, 0, 11'h155, 0, 1);
        set_vec(6,  1, NOP,   0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 0);
        set_vec(7,  0, CMP,   1, 0, 0, 11'h000, 0, 0, 11'h000, 0, 0);
        set_vec(8,  0, BRZM4, 0, 0, 0, 11'h000, 0, 1, 11'h7FC, 0, 1);
        set_vec(9,  0, CMP,   0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 1);
        set_vec(10, 0, BRZM4, 0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 1);
        set_vec(11, 0, BAZ3,  0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 1);
        set_vec(12, 0, CMP,   1, 0, 0, 11'h000, 0, 0, 11'h000, 0, 1);
        set_vec(13, 0, BAZ3,  0, 0, 0, 11'h000, 1, 0, 11'h155, 0, 2);
        set_vec(14, 0, BRZP,  0, 0, 0, 11'h000, 0, 1, 11'h00F, 0, 3);
        set_vec(15, 0, HALT,  0, 0, 0, 11'h000, 0, 0, 11'h000, 1, 3);
        set_vec(16, 0, BRA3,  0, 0, 0, 11'h000, 0, 1, 11'h000, 1, 3);
        set_vec(17, 1, NOP,   0, 0, 0, 11'h000, 0, 1, 11'h000, 0, 0);
        set_vec(18, 0, BRZM4, 0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 0);
        set_vec(19, 1, HALT,  0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 0);
        set_vec(20, 0, BRA3,  0, 0, 0, 11'h000, 1, 0, 11'h155, 0, 1);
        set_vec(21, 0, BRA5,  0, 1, 5, 11'h2AA, 1, 0, 11'h000, 0, 2);
        set_vec(22, 0, BRA5,  0, 0, 0, 11'h000, 1, 0, 11'h2AA, 0, 3);
        set_vec(23, 1, CMP,   1, 0, 0, 11'h000, 0, 0, 11'h000, 0, 0);
        set_vec(24, 0, BRZM4, 0, 0, 0, 11'h000, 0, 0, 11'h000, 0, 0);

        reset     = 1'b1;
        start     = 1'b0;
        instr     = NOP;
        ALU_flag  = 1'b0;
        lut_we    = 1'b0;
        lut_addr  = '0;
        lut_wdata = '0;

        #2;
        chk("rst_abs",  32'(branch_abs), 32'd0);
        chk("rst_rel",  32'(branch_rel), 32'd1);
        chk("rst_tgt",  32'(Target),     32'd0);
        chk("rst_done", 32'(done),       32'd0);
        chk("rst_cnt",  32'(taken_cnt),  32'd0);

        @(posedge ckl);
        @(posedge ckl);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            start     = vecs[i].start;
            instr     = vecs[i].instr;
            ALU_flag  = vecs[i].alu;
            lut_we    = vecs[i].we;
            lut_addr  = vecs[i].wa;
            lut_wdata = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_abs", i), 32'(branch_abs), 32'(vecs[i].e_abs));
            chk($sformatf("v%0d_rel", i), 32'(branch_rel), 32'(vecs[i].e_rel));
            chk($sformatf("v%0d_tgt", i), 32'(Target),     32'(vecs[i].e_tgt));
            @(posedge ckl);
            #1;
            chk($sformatf("v%0d_done", i), 32'(done),      32'(vecs[i].e_done));
            chk($sformatf("v%0d_cnt", i),  32'(taken_cnt), 32'(vecs[i].e_cnt));
        end

        // Saturation: RUN with count 0, then 65540 taken BRAs
        start    = 1'b0;
        lut_we   = 1'b0;
        ALU_flag = 1'b0;
        instr    = BRA5;
        repeat (65534) @(posedge ckl);
        #1;
        chk("sat_fffe", 32'(taken_cnt), 32'h0000_FFFE);
        repeat (6) @(posedge ckl);
        #1;
        chk("sat_ffff", 32'(taken_cnt), 32'h0000_FFFF);
        chk("sat_abs",  32'(branch_abs), 32'd1);
        chk("sat_tgt",  32'(Target),     32'h2AA);

        // Async reset mid-run, checked well before the next posedge
        #2;
        reset = 1'b1;
        #1;
        chk("arst_abs", 32'(branch_abs), 32'd0);
        chk("arst_rel", 32'(branch_rel), 32'd1);
        chk("arst_tgt", 32'(Target),     32'd0);
        chk("arst_cnt", 32'(taken_cnt),  32'd0);
        @(posedge ckl);
        #1;
        reset = 1'b0;

        // LUT must have been cleared by reset
        start = 1'b1;
        instr = NOP;
        @(posedge ckl);
        #1;
        start = 1'b0;
        instr = BRA5;
        #1;
        chk("lutclr_abs", 32'(branch_abs), 32'd1);
        chk("lutclr_tgt", 32'(Target),     32'd0);
        @(posedge ckl);
        #1;
        chk("lutclr_cnt", 32'(taken_cnt), 32'd1);

        // HALT then async reset while DONE
        instr = HALT;
        @(posedge ckl);
        #1;
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_rel",  32'(branch_rel), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst2_done", 32'(done), 32'd0);
        chk("arst2_cnt",  32'(taken_cnt), 32'd0);
        @(posedge ckl);
        #1;
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Control-flow unit that decodes the current instruction and drives the branch inputs of the instruction fetch unit (`branch_abs`, `branch_rel`, `Target`). It also runs the per-program start/halt handshake with the test bench. It sits between instruction memory output and the fetch unit's PC update logic. It owns a programmable branch-target lookup table, a latched condition flag, and a taken-branch counter.

## Interface
Parameters:
- PC_WIDTH, 11, width of PC and `Target`
- INSTR_WIDTH, 9, instruction width
- LUT_DEPTH, 16, number of absolute branch target entries (index = instr[3:0])

Ports:
- ckl  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately
- start  in  1  bench request to begin the next program
- instr  in  INSTR_WIDTH  instruction currently addressed by the PC
- ALU_flag  in  1  ALU condition flag for the current instruction
- lut_we  in  1  target LUT write enable
- lut_addr  in  4  target LUT write index
- lut_wdata  in  PC_WIDTH  target LUT write data
- branch_abs  out  1  fetch loads `Target`
- branch_rel  out  1  fetch adds `Target` to PC
- Target  out  PC_WIDTH  branch target or offset
- done  out  1  program halted; held until next `start`
- taken_cnt  out  16  branches taken since last `start`, saturating

## Operation
- Opcode is instr[8:5]. Decoded only in state RUN:
  - 1110 BRA: unconditional absolute branch; `branch_abs`=1, `Target`=LUT[instr[3:0]].
  - 1101 BAZ: absolute branch to LUT[instr[3:0]] if flag_q=1.
  - 1100 BRZ: relative branch if flag_q=1; `Target` = sign-extend(instr[4:0]) to PC_WIDTH; offset range -16..+15.
  - 1010 CMP: flag_q <= ALU_flag at the next edge; no branch.
  - 1111 HALT: enter DONE.
  - All others: no branch. `branch_abs`=`branch_rel`=0, `Target`=0.
- A not-taken conditional branch drives both branch outputs 0 and `Target`=0.
- `branch_abs` and `branch_rel` are never both 1.
- State machine has three states: IDLE, RUN, DONE.
  - Reset goes to IDLE.
  - `start`=1 in any state goes to RUN.
  - HALT in RUN goes to DONE.
  - DONE holds until `start`.
- In IDLE and DONE, PC freeze: `branch_rel`=1, `Target`=0, `branch_abs`=0.
- `done` is registered: 1 exactly while in DONE.
- On `start`: flag_q <= 0 and taken_cnt <= 0 at the same edge.
- taken_cnt increments by 1 per taken branch in RUN; saturates at 16'hFFFF.
- LUT is a register array written at posedge when `lut_we`=1, in any state.
- LUT reads are combinational.
- Reset values:
  - branch_abs=0, branch_rel=1, Target=0, done=0, taken_cnt=0.
  - flag_q=0, all LUT entries=0.

## Timing
- Branch outputs are combinational from instr, state, flag_q and LUT, valid the same cycle as instr.
- Fetch applies the branch at the following edge, so branch latency is one edge.
- CMP flag is visible to a conditional branch in the immediately following instruction (one edge).
- `start` and HALT in the same cycle: `start` wins; next state is RUN and `done` stays 0.
- `start` in RUN restarts: counters and flag are cleared, state remains RUN.
- During the `start` cycle, outputs follow the current state. The state is not yet RUN, so the PC freeze is applied, and fetch's own `start` zeroes the PC.
- LUT write and branch read to the same index in the same cycle: the read returns the old value; the new value is used from the next cycle.
- Reset asserted mid-program: outputs go to reset values asynchronously without waiting for `ckl`; LUT contents are cleared.

## Test plan
- Reset, then idle 3 cycles with no `start` -> branch_rel=1, Target=0, done=0, taken_cnt=0 throughout.
- Write LUT[3]=11'h155. `start`, then instr=9'b1110_0_0011 -> branch_abs=1, Target=11'h155, taken_cnt=1 after the edge.
- `start`, CMP with ALU_flag=1, next instr BRZ with instr[4:0]=5'b11100 -> branch_rel=1, Target=11'h7FC (-4). Repeat with ALU_flag=0 -> no branch, taken_cnt unchanged.
- HALT in RUN -> done=1 from the next edge and PC freeze is driven. `start` -> done=0 the next cycle, and taken_cnt and flag_q are cleared.
- Raise `start` and present HALT in the same cycle -> state RUN, done=0. Separately, LUT write to index 5 in the same cycle as BRA 5 -> old Target, new value on the following cycle.
- Issue 65,540 taken BRAs -> taken_cnt holds 16'hFFFF. Assert reset asynchronously mid-run -> all outputs return to reset values before the next posedge.
